// File: rtl/lo_adc_stream.sv
// lo_adc_stream: LF ADC front end to ARM SSP streamer.
// Divides pck0 into the ADC/antenna clock, samples adc_d once per ADC clock
// period, box-car averages 2^AVG_LOG2 samples and shifts each result out as a
// framed, zero-padded FRAME_W-bit word, MSB first.
// Optional feature macro: LO_ADC_STREAM_OVR_EN (sticky overrun flag plus
// in-band marking of the frame LSB after a dropped word).
module lo_adc_stream #(
   parameter int ADC_W    = 8,
   parameter int DIV_W    = 8,
   parameter int AVG_LOG2 = 0,
   parameter int FRAME_W  = 16
) (
   input  logic             pck0,
   input  logic             rst_n,
   input  logic [ADC_W-1:0] adc_d,
   input  logic [DIV_W-1:0] divisor,
   input  logic             lf_field,
   input  logic             ssp_dout,
   output logic             ssp_din,
   output logic             ssp_frame,
   output logic             ssp_clk,
   output logic             adc_clk,
   output logic             pwr_lo,
   output logic             pwr_hi,
   output logic             pwr_oe1,
   output logic             pwr_oe2,
   output logic             pwr_oe3,
   output logic             pwr_oe4,
   output logic             ovr_flag,
   output logic             debug
);

   localparam int ACC_W = ADC_W + AVG_LOG2;
   localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam int BC_W  = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;

   typedef enum logic {
      IDLE,
      SHIFT
   } state_e;

   // ---------------------------------------------------------------------
   // Clock divider
   // ---------------------------------------------------------------------
   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic             clk_state_q, clk_state_d;
   logic             tick;
   logic             strobe;

   // Next divider state; >= lets a lowered divisor wrap at once instead of
   // running the counter out to 2^DIV_W.
   always_comb begin
      // NOTE: every output of a combinational block gets a value on every path
      // (here directly, below by defaults first) so no latch is inferred.
      tick        = (div_cnt_q >= divisor);
      strobe      = tick & clk_state_q;
      div_cnt_d   = tick ? '0 : div_cnt_q + DIV_W'(1);
      clk_state_d = clk_state_q ^ tick;
   end

   // Divider registers with synchronous reset.
   always_ff @(posedge pck0) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the pre-edge value of every other register.
      if (!rst_n) begin
         div_cnt_q   <= '0;
         clk_state_q <= 1'b0;
      end else begin
         div_cnt_q   <= div_cnt_d;
         clk_state_q <= clk_state_d;
      end
   end

   // ---------------------------------------------------------------------
   // Box-car accumulator
   // ---------------------------------------------------------------------
   logic [ACC_W-1:0] acc_q;
   logic [CNT_W-1:0] acc_cnt_q;
   logic [ACC_W-1:0] sum;
   logic             last_sample;
   logic [ADC_W-1:0] word_q;
   logic             word_valid_q;

   // Running sum including the sample captured on this strobe.
   always_comb begin
      sum         = acc_q + ACC_W'(adc_d);
      last_sample = (acc_cnt_q == CNT_W'((1 << AVG_LOG2) - 1));
   end

   // Accumulate on each strobe; emit the truncated mean as a one-cycle word.
   always_ff @(posedge pck0) begin
      if (!rst_n) begin
         acc_q        <= '0;
         acc_cnt_q    <= '0;
         word_q       <= '0;
         word_valid_q <= 1'b0;
      end else begin
         word_valid_q <= 1'b0;
         if (strobe) begin
            if (last_sample) begin
               word_q       <= ADC_W'(sum >> AVG_LOG2);
               word_valid_q <= 1'b1;
               acc_q        <= '0;
               acc_cnt_q    <= '0;
            end else begin
               acc_q     <= sum;
               acc_cnt_q <= acc_cnt_q + CNT_W'(1);
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Serializer
   // ---------------------------------------------------------------------
   state_e             state_q;
   logic [FRAME_W-1:0] sr_q;
   logic [BC_W-1:0]    bit_cnt_q;
   logic               frame_q;
   logic               bit_last;
   logic [BC_W-1:0]    lsb_pos;
   logic [FRAME_W-1:0] load_word;
   logic [FRAME_W-1:0] shift_word;

`ifdef LO_ADC_STREAM_OVR_EN
   logic ovr_q;
   logic drop;

   // A word arriving mid-frame cannot be queued; it is lost.
   assign drop = word_valid_q && (state_q == SHIFT) && !bit_last;
`endif

   // Frame contents to load and to shift; after an overrun the original
   // frame LSB (which sits at index bit_cnt+1 after the shift) is forced to 1.
   always_comb begin
      bit_last   = (bit_cnt_q == BC_W'(FRAME_W - 1));
      lsb_pos    = bit_cnt_q + BC_W'(1);
      load_word  = FRAME_W'(word_q) << (FRAME_W - ADC_W);
      shift_word = sr_q << 1;
`ifdef LO_ADC_STREAM_OVR_EN
      if (ovr_q) load_word[0] = 1'b1;
      if ((ovr_q || drop) && !bit_last) shift_word[lsb_pos] = 1'b1;
`endif
   end

   // Serializer FSM with registered frame marker and data bit.
   always_ff @(posedge pck0) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         sr_q      <= '0;
         bit_cnt_q <= '0;
         frame_q   <= 1'b0;
`ifdef LO_ADC_STREAM_OVR_EN
         ovr_q     <= 1'b0;
`endif
      end else begin
         frame_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (word_valid_q) begin
                  sr_q      <= load_word;
                  bit_cnt_q <= '0;
                  frame_q   <= 1'b1;
                  state_q   <= SHIFT;
               end
            end
            SHIFT: begin
               if (bit_last) begin
                  bit_cnt_q <= '0;
                  if (word_valid_q) begin
                     sr_q    <= load_word;
                     frame_q <= 1'b1;
                  end else begin
                     sr_q    <= '0;
                     state_q <= IDLE;
                  end
               end else begin
                  sr_q      <= shift_word;
                  bit_cnt_q <= bit_cnt_q + BC_W'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
`ifdef LO_ADC_STREAM_OVR_EN
         if (drop) ovr_q <= 1'b1;
`endif
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign ssp_din   = sr_q[FRAME_W-1];
   assign ssp_frame = frame_q;
   assign ssp_clk   = pck0;
   assign adc_clk   = ~clk_state_q;
   assign debug     = adc_clk;
   assign pwr_lo    = ~ssp_dout & lf_field & clk_state_q;
   assign pwr_oe3   = ssp_dout & ~lf_field;
   assign pwr_hi    = 1'b0;
   assign pwr_oe1   = 1'b0;
   assign pwr_oe2   = 1'b0;
   assign pwr_oe4   = 1'b0;
`ifdef LO_ADC_STREAM_OVR_EN
   assign ovr_flag  = ovr_q;
`else
   assign ovr_flag  = 1'b0;
`endif

endmodule

// File: doc/lo_adc_stream.md
Name: lo_adc_stream

Overview:
- Parametrised successor to the LF ADC pass-through block.
- Divides pck0 into the antenna/ADC clock phase and samples the ADC once per ADC clock period.
- Optionally box-car averages 2^AVG_LOG2 samples, then streams each result to the ARM SSP as a framed, zero-padded FRAME_W-bit word, MSB first.
- Sits between the LF front end (adc_d, pwr_*) and the ARM SSP, and replaces the fixed 8-bit / ungated-frame LF reader path.

Parameters:
- ADC_W, 8: ADC sample width in bits.
- DIV_W, 8: width of the divisor input and of the internal divider counter.
- AVG_LOG2, 0: log2 of the samples averaged per output word; legal range 0..4.
- FRAME_W, 16: SSP word length in bits; must be >= ADC_W.

Ports:
- pck0, input, 1: 24 MHz system clock; all logic on its rising edge.
- rst_n, input, 1: synchronous active-low reset.
- adc_d, input, ADC_W: ADC data.
- divisor, input, DIV_W: half-period of the ADC clock, minus 1.
- lf_field, input, 1: reader mode (1) or tag/sim mode (0).
- ssp_dout, input, 1: ARM modulation bit.
- ssp_din, output, 1: serial sample data to the ARM.
- ssp_frame, output, 1: word start marker.
- ssp_clk, output, 1: equals pck0.
- adc_clk, output, 1: ADC conversion clock.
- pwr_lo, pwr_hi, pwr_oe1, pwr_oe2, pwr_oe3, pwr_oe4: outputs, 1 bit each; antenna drivers.
- ovr_flag, output, 1: sticky overrun indicator (see Optional Feature).
- debug, output, 1: equals adc_clk.

Behaviour:
- Reset (rst_n=0 at a pck0 edge) forces:
  - div_cnt=0, clk_state=0, acc=0, acc_cnt=0.
  - FSM=IDLE, shift register=0, ovr_flag=0.
  - Resulting outputs: ssp_din=0, ssp_frame=0, adc_clk=1, pwr_lo=0, pwr_oe3=ssp_dout&!lf_field.
  - Reset mid-word aborts the word; no partial data is replayed.
- Divider:
  - tick is asserted when div_cnt >= divisor; on tick, div_cnt<=0 and clk_state toggles. Otherwise div_cnt increments.
  - The >= compare makes lowering divisor mid-count wrap on the next cycle; there is no 2^DIV_W run-out.
  - divisor=0 toggles clk_state every cycle.
- adc_clk = ~clk_state. debug = adc_clk.
- Sample strobe:
  - Asserted on tick while clk_state==1, i.e. the cycle adc_clk rises. adc_d is captured on that edge.
  - One sample per 2*(divisor+1) cycles.
- Accumulator:
  - acc is (ADC_W+AVG_LOG2) bits wide. On a strobe, acc<=acc+adc_d and acc_cnt increments.
  - When acc_cnt reaches 2^AVG_LOG2-1 on a strobe: word = (acc+adc_d)>>AVG_LOG2 (truncating), word_valid pulses for 1 cycle, and acc and acc_cnt clear.
  - AVG_LOG2=0: word equals the captured sample; latency 1 cycle from strobe to word_valid.
- Serializer FSM, states IDLE and SHIFT, with bit_cnt of log2(FRAME_W) bits:
  - IDLE + word_valid → load sr={word, FRAME_W-ADC_W zeros}, bit_cnt=0, go to SHIFT.
  - SHIFT: ssp_din=sr[FRAME_W-1]; sr shifts left, zero-filled, each cycle; bit_cnt increments.
  - ssp_frame=1 only in the SHIFT cycle with bit_cnt==0.
  - In the SHIFT cycle with bit_cnt==FRAME_W-1:
    - If word_valid, reload and stay in SHIFT for back-to-back words with no gap.
    - Otherwise go to IDLE.
  - word_valid in SHIFT with bit_cnt != FRAME_W-1 → word dropped, current word completes intact, overrun event raised.
  - IDLE outputs: ssp_din=0, ssp_frame=0.
- Antenna outputs (combinational from the registered clk_state):
  - pwr_lo = !ssp_dout & lf_field & clk_state.
  - pwr_oe3 = ssp_dout & !lf_field.
  - pwr_hi = pwr_oe1 = pwr_oe2 = pwr_oe4 = 0.
- Throughput: loss-free when 2*(divisor+1)*2^AVG_LOG2 >= FRAME_W.

Optional Feature:
- Macro: LO_ADC_STREAM_OVR_EN.
- Defined:
  - ovr_flag goes to 1 on the cycle after any dropped word and stays 1 until reset.
  - While ovr_flag=1, bit 0 of every transmitted frame is forced to 1 so the ARM can detect loss in-band. This requires FRAME_W > ADC_W; if FRAME_W==ADC_W, the data LSB is overwritten.
- Undefined: ovr_flag is tied to 0, there is no overrun logic, and the frame LSB pad stays 0.

Test Plan:
- Reset, then hold rst_n=0 for 5 cycles with ssp_dout=1, lf_field=0 → ssp_din=0, ssp_frame=0, adc_clk=1, pwr_lo=0, pwr_oe3=1, ovr_flag=0.
- divisor=7, AVG_LOG2=0, FRAME_W=16, adc_d=8'hA5 constant → adc_clk period 16 cycles; back-to-back frames; ssp_frame high 1 of every 16 cycles; bit stream 1010_0101_0000_0000; no idle gap.
- AVG_LOG2=2, divisor=3, adc_d sequence 10,20,30,41 → one frame carrying 8'd25 (101>>2); frame starts 2 cycles after the 4th strobe (word_valid 1 cycle, then load).
- divisor=1, AVG_LOG2=0, FRAME_W=16 (period 4 < 16), macro defined → 3 of every 4 words dropped; ovr_flag rises after the first drop; subsequent frames have LSB=1.
- divisor changed from 200 to 3 while div_cnt=150 → tick on the next cycle, then a steady 4-cycle half-period; no stall.
- lf_field=1, ssp_dout=0 → pwr_lo follows clk_state; set ssp_dout=1 → pwr_lo=0 in the same cycle.
